load_store_unit: RTL and testbench

// - Sits between the datapath and data_memory. Accepts one load/store request at a time (valid/ready).
// - Drives the word-aligned data_memory port. data_memory reads combinationally and writes on the clock edge.
// - Adds byte and halfword access: sub-word stores use read-modify-write; loads sign- or zero-extend.
// - Big-endian byte lanes, matching instruction_memory: byte offset 0 = bits [31:24].

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit in front of a word-aligned data memory
//
// Purpose: accepts one load/store at a time, checks alignment/range/size, performs
// read-modify-write for sub-word stores and sign/zero extension for loads.
// Big-endian lanes: byte offset 0 is bits [31:24].
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (accepted when both high)
//   req_write, req_size,        store flag, 00 byte / 01 half / 10 word / 11 illegal,
//   req_unsigned                zero-extend loads
//   req_adress, req_wdata       byte address, store data (byte [7:0], half [15:0])
//   resp_valid, resp_rdata,     one-cycle response, extended load data,
//   resp_error                  misaligned / out-of-range / illegal size
//   mem_write_enable,           data memory write strobe,
//   mem_adress, mem_write_data  word-aligned address, write data
//   mem_read_data               combinational read data from data memory
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_adress,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_write_enable,
    output logic [31:0] mem_adress,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        err_q;

    logic        accept;
    logic        req_error;
    logic [1:0]  lane;
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] merged;
    logic [31:0] load_data;
    logic [31:0] byte_word;
    logic [31:0] half_word;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_error = 1'b0;
        if (req_size == 2'b11)
            req_error = 1'b1;
        if (req_size == 2'b01 && req_adress[0] != 1'b0)
            req_error = 1'b1;
        if (req_size == 2'b10 && req_adress[1:0] != 2'b00)
            req_error = 1'b1;
        if ({2'b00, req_adress[31:2]} >= 32'(MEM_WORDS))
            req_error = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= 32'h0;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'h0;
            word_q     <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q     <= req_adress;
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
                err_q      <= req_error;
            end
            if (state == READ)
                word_q <= mem_read_data;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_error)
                        state_next = RESP;
                    else if (req_write && req_size == 2'b10)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = write_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane L sits at bit 8*(3-L) for bytes and 8*(2-L) for halves (L is 0 or 2).
    assign lane       = addr_q[1:0];
    assign byte_shift = {~lane, 3'b000};
    assign half_shift = {~lane[1], 4'b0000};

    always_comb begin
        merged = wdata_q;
        case (size_q)
            2'b00: merged = (word_q & ~(32'h0000_00FF << byte_shift))
                          | ({24'h0, wdata_q[7:0]} << byte_shift);
            2'b01: merged = (word_q & ~(32'h0000_FFFF << half_shift))
                          | ({16'h0, wdata_q[15:0]} << half_shift);
            default: merged = wdata_q;
        endcase
    end

    assign byte_word = word_q >> byte_shift;
    assign half_word = word_q >> half_shift;

    always_comb begin
        load_data = word_q;
        case (size_q)
            2'b00: load_data = {{24{~unsigned_q & byte_word[7]}}, byte_word[7:0]};
            2'b01: load_data = {{16{~unsigned_q & half_word[15]}}, half_word[15:0]};
            default: load_data = word_q;
        endcase
    end

    // Reset gates every output so an aborted request can neither write nor respond.
    assign resp_valid       = (state == RESP) && !reset;
    assign resp_error       = resp_valid && err_q;
    assign resp_rdata       = (resp_valid && !err_q && !write_q) ? load_data : 32'h0;
    assign mem_write_enable = (state == WRITE) && !reset;
    assign mem_write_data   = mem_write_enable ? merged : 32'h0;
    assign mem_adress       = (state != IDLE && !reset) ? {addr_q[31:2], 2'b00} : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_adress;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_enable;
    logic [31:0] mem_adress;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:63];
    int          wr_count;
    int          checks = 0;
    int          errors = 0;
    int          seen_resp;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_adress       (req_adress),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_adress       (mem_adress),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_adress[7:2]];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_adress[7:2]] <= mem_write_data;
            wr_count = wr_count + 1;
        end
    end

    always @(negedge clk) begin
        if (resp_valid)
            seen_resp = seen_resp + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and verify latency, error flag, read data and write count.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_writes);
        int          lat;
        logic        err;
        logic [31:0] rdata;
        lat   = 0;
        err   = 1'bx;
        rdata = 32'hx;
        @(negedge clk);
        wr_count = 0;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_adress   = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat   = i;
                err   = resp_error;
                rdata = resp_rdata;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " error"}, 32'(err), 32'(exp_err));
        check({tag, " rdata"}, rdata, exp_rdata);
        @(negedge clk);
        check({tag, " pulse"}, 32'(resp_valid), 32'd0);
        check({tag, " writes"}, 32'(wr_count), 32'(exp_writes));
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'h0;
        wr_count     = 0;
        seen_resp    = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_adress   = 32'h0;
        req_wdata    = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_error", 32'(resp_error), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst we", 32'(mem_write_enable), 32'd0);
        check("rst adress", mem_adress, 32'h0);
        check("rst wdata", mem_write_data, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst ready", 32'(req_ready), 32'd1);

        do_req("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1);
        check("sw mem", mem[4], 32'hDEADBEEF);
        do_req("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);

        @(negedge clk);
        mem[4] = 32'h11223344;
        do_req("sb", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 3, 1'b0, 32'h0, 1);
        check("sb mem", mem[4], 32'h11AA3344);
        do_req("lb", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 1'b0, 32'hFFFFFFAA, 0);
        do_req("lbu", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 1'b0, 32'h000000AA, 0);
        do_req("lb0", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h00000011, 0);

        do_req("sh", 1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 3, 1'b0, 32'h0, 1);
        check("sh mem", mem[4], 32'h11AA8001);
        do_req("lh", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF8001, 0);
        do_req("lhu", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'h00008001, 0);
        do_req("lh0", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h000011AA, 0);

        do_req("lw mis", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("sh mis", 1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, 1, 1'b1, 32'h0, 0);
        do_req("sw oor", 1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 1, 1'b1, 32'h0, 0);
        do_req("size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("sw last", 1'b1, 2'b10, 1'b0, 32'hFC, 32'h0BADF00D, 2, 1'b0, 32'h0, 1);
        check("sw last mem", mem[63], 32'h0BADF00D);
        check("err mem4", mem[4], 32'h11AA8001);

        // Abort a sub-word store by asserting reset during its WRITE cycle.
        @(negedge clk);
        wr_count     = 0;
        seen_resp    = 0;
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_adress   = 32'h10;
        req_wdata    = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort in write", 32'(mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        check("abort we gated", 32'(mem_write_enable), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort idle", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("abort writes", 32'(wr_count), 32'd0);
        check("abort resp", 32'(seen_resp), 32'd0);
        check("abort mem", mem[4], 32'h11AA8001);

        do_req("lw after", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h11AA8001, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
